// File: rtl/pipe_scoreboard.sv
//------------------------------------------------------------------------------
// Module  : pipe_scoreboard
// Purpose : Per-register latency countdown scoreboard that stalls ID issue on
//           RAW and WAW hazards, with pipeline freeze and branch flush.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipe_scoreboard #(
   parameter int NUM_REGS = 32,
   parameter int REG_AW   = 5,
   parameter int CNT_W    = 3,
   parameter int MAX_LAT  = 7,
   parameter bit R0_ZERO  = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                issue_valid,
   input  logic [REG_AW-1:0]   src1,
   input  logic                src1_used,
   input  logic [REG_AW-1:0]   src2,
   input  logic                src2_used,
   input  logic [REG_AW-1:0]   dest,
   input  logic                dest_wen,
   input  logic [CNT_W-1:0]    dest_lat,
   input  logic                freeze,
   input  logic                flush,
   output logic                stall,
   output logic                issue_fire,
   output logic [NUM_REGS-1:0] pending,
   output logic [REG_AW:0]     inflight,
   output logic                lat_err
);

   localparam logic [CNT_W-1:0] c_max_lat = CNT_W'(MAX_LAT);

   logic [CNT_W-1:0] w_cnt [NUM_REGS];
   logic             w_raw1;
   logic             w_raw2;
   logic             w_waw;
   logic             w_lat_over;
   logic [CNT_W-1:0] w_load_val;
   logic             w_load;
   logic             r_lat_err;

   assign w_raw1 = src1_used & (w_cnt[src1] != '0);
   assign w_raw2 = src2_used & (w_cnt[src2] != '0);
   // A younger write must not complete before an older one to the same reg.
   assign w_waw  = dest_wen & (w_cnt[dest] > dest_lat);

   assign stall      = issue_valid & (w_raw1 | w_raw2 | w_waw);
   assign issue_fire = issue_valid & ~stall & ~freeze & ~flush;

   assign w_lat_over = (dest_lat > c_max_lat);
   assign w_load_val = w_lat_over ? c_max_lat : dest_lat;
   assign w_load     = issue_fire & dest_wen;

   genvar i;
   generate
      for (i = 0; i < NUM_REGS; i++) begin : g_reg
         if (R0_ZERO && (i == 0)) begin : g_zero
            assign w_cnt[i] = '0;
         end else begin : g_cnt
            logic [CNT_W-1:0] r_cnt;

            // A fresh load wins over this register's own decrement.
            always_ff @(posedge clk) begin
               if (rst) begin
                  r_cnt <= '0;
               end else if (!freeze) begin
                  if (w_load && (dest == REG_AW'(i))) begin
                     r_cnt <= w_load_val;
                  end else if (r_cnt != '0) begin
                     r_cnt <= r_cnt - 1'b1;
                  end
               end
            end

            assign w_cnt[i] = r_cnt;
         end

         assign pending[i] = (w_cnt[i] != '0);
      end
   endgenerate

   always_comb begin
      inflight = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         inflight = inflight + (REG_AW+1)'(pending[k]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_lat_err <= 1'b0;
      end else if (issue_fire && w_lat_over) begin
         r_lat_err <= 1'b1;
      end
   end

   assign lat_err = r_lat_err;

endmodule

`default_nettype wire

// File: tb/tb_pipe_scoreboard.sv
//------------------------------------------------------------------------------
// Module  : tb_pipe_scoreboard
// Purpose : Scoreboard bench for pipe_scoreboard against a per-register
//           countdown reference model (MAX_LAT reduced to 5).
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipe_scoreboard;

   localparam int c_num_regs = 32;
   localparam int c_max_lat  = 5;

   typedef struct {
      logic        stall;
      logic        fire;
      logic [31:0] pending;
      logic [5:0]  inflight;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        issue_valid = 1'b0;
   logic [4:0]  src1 = '0;
   logic        src1_used = 1'b0;
   logic [4:0]  src2 = '0;
   logic        src2_used = 1'b0;
   logic [4:0]  dest = '0;
   logic        dest_wen = 1'b0;
   logic [2:0]  dest_lat = '0;
   logic        freeze = 1'b0;
   logic        flush = 1'b0;
   logic        stall;
   logic        issue_fire;
   logic [31:0] pending;
   logic [5:0]  inflight;
   logic        lat_err;

   int   n_pass  = 0;
   int   n_total = 0;
   exp_t exp_q[$];

   // reference state: remaining cycles before each register's result is usable
   int m_cnt [c_num_regs];
   bit m_err;

   always #5 clk = ~clk;

   pipe_scoreboard #(
      .NUM_REGS (32),
      .REG_AW   (5),
      .CNT_W    (3),
      .MAX_LAT  (c_max_lat),
      .R0_ZERO  (1'b1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .issue_valid (issue_valid),
      .src1        (src1),
      .src1_used   (src1_used),
      .src2        (src2),
      .src2_used   (src2_used),
      .dest        (dest),
      .dest_wen    (dest_wen),
      .dest_lat    (dest_lat),
      .freeze      (freeze),
      .flush       (flush),
      .stall       (stall),
      .issue_fire  (issue_fire),
      .pending     (pending),
      .inflight    (inflight),
      .lat_err     (lat_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
   endtask

   // Drive one cycle, predict the visible outputs, then advance the model past the edge.
   task automatic drive(input bit iv, input int s1, input bit s1u, input int s2, input bit s2u,
                        input int d, input bit dw, input int lat, input bit frz, input bit fl);
      exp_t e;
      bit   hz;
      @(negedge clk);
      rst = 1'b0; issue_valid = iv; src1 = 5'(s1); src1_used = s1u; src2 = 5'(s2);
      src2_used = s2u; dest = 5'(d); dest_wen = dw; dest_lat = 3'(lat); freeze = frz; flush = fl;
      hz = (s1u && m_cnt[s1] > 0) || (s2u && m_cnt[s2] > 0) || (dw && m_cnt[d] > lat);
      e.stall    = iv && hz;
      e.fire     = iv && !hz && !frz && !fl;
      e.pending  = '0;
      e.inflight = '0;
      for (int r = 0; r < c_num_regs; r++) begin
         if (m_cnt[r] > 0) begin
            e.pending[r] = 1'b1;
            e.inflight++;
         end
      end
      e.err = m_err;
      exp_q.push_back(e);
      if (!frz) begin
         for (int r = 0; r < c_num_regs; r++) if (m_cnt[r] > 0) m_cnt[r]--;
         if (e.fire && dw && d != 0) m_cnt[d] = (lat > c_max_lat) ? c_max_lat : lat;
      end
      if (e.fire && lat > c_max_lat) m_err = 1'b1;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset(input int n);
      repeat (n) begin
         @(negedge clk);
         rst = 1'b1; issue_valid = 1'b0; freeze = 1'b0; flush = 1'b0;
      end
      for (int r = 0; r < c_num_regs; r++) m_cnt[r] = 0;
      m_err = 1'b0;
   endtask

   // Hold a request until it issues; reports how many cycles it stalled.
   task automatic issue_until_fire(input int s1, input bit s1u, input int s2, input bit s2u,
                                   input int d, input bit dw, input int lat, output int stalls);
      bit done = 1'b0;
      stalls = 0;
      for (int k = 0; k < 20 && !done; k++) begin
         drive(1, s1, s1u, s2, s2u, d, dw, lat, 0, 0);
         #1;
         if (issue_fire) done = 1'b1;
         else if (stall) stalls++;
      end
      if (!done) chk("issue_timeout", 32'(done), 32'd1);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("stall",      32'(stall),      32'(e.stall));
            chk("issue_fire", 32'(issue_fire), 32'(e.fire));
            chk("pending",    pending,         e.pending);
            chk("inflight",   32'(inflight),   32'(e.inflight));
            chk("lat_err",    32'(lat_err),    32'(e.err));
         end
      end
   end

   initial begin : stim
      int st;
      do_reset(2);
      drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);

      issue_until_fire(0, 0, 0, 0, 5, 1, 1, st);
      issue_until_fire(5, 1, 0, 0, 0, 0, 0, st);
      chk("load_use_stalls", 32'(st), 32'd1);
      idle(); idle();

      issue_until_fire(0, 0, 0, 0, 5, 1, 2, st);
      issue_until_fire(0, 0, 5, 1, 0, 0, 0, st);
      chk("lat2_stalls", 32'(st), 32'd2);
      idle(); idle();

      issue_until_fire(0, 0, 0, 0, 0, 1, 3, st);
      issue_until_fire(0, 1, 0, 1, 0, 0, 0, st);
      chk("r0_stalls", 32'(st), 32'd0);

      issue_until_fire(0, 0, 0, 0, 7, 1, 3, st);
      issue_until_fire(0, 0, 0, 0, 7, 1, 1, st);
      chk("waw_stalls", 32'(st), 32'd2);
      idle(); idle();

      issue_until_fire(0, 0, 0, 0, 9, 1, 3, st);
      idle();
      repeat (3) drive(1, 1, 1, 2, 1, 12, 1, 2, 1, 0);
      #1 chk("freeze_hold_r9", 32'(pending[9]), 32'd1);
      drive(1, 1, 1, 2, 1, 12, 1, 2, 0, 1);
      idle(); idle(); idle();

      issue_until_fire(0, 0, 0, 0, 11, 1, 7, st);
      idle();
      #1 chk("lat_err_set", 32'(lat_err), 32'd1);
      idle();
      do_reset(1);
      idle();
      #1 chk("rst_clears", 32'({lat_err, pending != 0}), 32'd0);

      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 99) == 0) begin
            do_reset(1);
         end else begin
            drive($urandom_range(0, 3) != 0,
                  $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
         end
      end

      repeat (3) @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
